// File: rtl/axi_rom_burst.sv
// AXI4 read-only boot ROM slave: FIXED/INCR/WRAP read bursts against a pipelined ROM macro,
// credit-controlled skid FIFO on R, bounds-checked beats, SLVERR for every write.

package ariane_axi;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned UserWidth = 1;

  typedef logic [AddrWidth-1:0]   addr_t;
  typedef logic [DataWidth-1:0]   data_t;
  typedef logic [DataWidth/8-1:0] strb_t;
  typedef logic [IdWidth-1:0]     id_t;
  typedef logic [UserWidth-1:0]   user_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    user_t       user;
  } aw_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
    user_t user;
  } w_chan_t;

  typedef struct packed {
    id_t        id;
    logic [1:0] resp;
    user_t      user;
  } b_chan_t;

  typedef struct packed {
    id_t         id;
    addr_t       addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    user_t       user;
  } ar_chan_t;

  typedef struct packed {
    id_t        id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
    user_t      user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } resp_t;
endpackage

module axi_rom_burst #(
  parameter int unsigned AxiAddrWidth = 64,
  parameter int unsigned AxiDataWidth = 64,
  parameter int unsigned AxiIdWidth   = 4,
  parameter int unsigned AxiUserWidth = 1,
  parameter int unsigned RomWords     = 1024,
  parameter int unsigned RomLatency   = 1,
  parameter logic [AxiAddrWidth-1:0] BaseAddr = 64'h1_0000
) (
  input  logic                        clk,
  input  logic                        ndmreset,
  input  ariane_axi::req_t            axi_req_i,
  output ariane_axi::resp_t           axi_resp_o,
  output logic                        rom_req_o,
  output logic [$clog2(RomWords)-1:0] rom_addr_o,
  input  logic [AxiDataWidth-1:0]     rom_rdata_i
);

  localparam int unsigned IdxW = $clog2(RomWords);
  localparam int unsigned OffW = $clog2(AxiDataWidth/8);
  localparam int unsigned D    = RomLatency + 1;
  localparam int unsigned CrW  = $clog2(D+1);
  localparam int unsigned PtrW = $clog2(D);
  localparam logic [AxiUserWidth-1:0] UserZero = '0;

  typedef logic [AxiAddrWidth-1:0] addr_t;
  typedef enum logic {R_IDLE, R_ISSUE} rstate_e;
  typedef enum logic [1:0] {W_IDLE, W_DRAIN, W_RESP} wstate_e;

  rstate_e               rstate_q, rstate_d;
  wstate_e               wstate_q, wstate_d;
  logic                  init_q;
  logic [AxiIdWidth-1:0] rid_q, rid_d, wid_q, wid_d;
  addr_t                 raddr_q, raddr_d;
  logic [7:0]            rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]            rsize_q, rsize_d;
  logic [1:0]            rburst_q, rburst_d;
  logic                  rdone_q, rdone_d;
  logic [CrW-1:0]        credits_q, credits_d;

  logic [RomLatency-1:0] dl_vld_q, dl_err_q, dl_last_q;

  logic [AxiDataWidth-1:0] fdata_q [D];
  logic [1:0]              fresp_q [D];
  logic                    flast_q [D];
  logic [PtrW-1:0]         wptr_q, rptr_q;
  logic [CrW-1:0]          fcnt_q;

  logic  ar_ready, aw_ready, w_ready, b_valid;
  logic  r_valid, r_last, r_hs, issue, beat_err, push, ar_wrap_ok;
  addr_t beat_bytes, wrap_mask, incr_addr, next_addr, word_off, idx;
  logic  unused_req;

  assign unused_req = ^axi_req_i;

  // Beat address arithmetic, all at full address width
  assign beat_bytes = addr_t'(1) << rsize_q;
  assign wrap_mask  = ((addr_t'(rlen_q) + addr_t'(1)) << rsize_q) - addr_t'(1);
  assign incr_addr  = (raddr_q & ~(beat_bytes - addr_t'(1))) + beat_bytes;
  assign word_off   = raddr_q - BaseAddr;
  assign idx        = word_off >> OffW;
  assign beat_err   = (raddr_q < BaseAddr) || (idx >= addr_t'(RomWords));
  assign ar_wrap_ok = axi_req_i.ar.len inside {8'd1, 8'd3, 8'd7, 8'd15};

  always_comb begin
    next_addr = incr_addr;
    case (rburst_q)
      2'b00:   next_addr = raddr_q;
      2'b10:   next_addr = (raddr_q & ~wrap_mask) | ((raddr_q + beat_bytes) & wrap_mask);
      default: next_addr = incr_addr;
    endcase
  end

  assign r_valid = (fcnt_q != '0);
  assign r_last  = flast_q[rptr_q];
  assign r_hs    = r_valid && axi_req_i.r_ready;
  // A credit returned by this cycle's R handshake may be spent immediately, so a
  // full pipeline of D entries streams without bubbles.
  assign issue      = (rstate_q == R_ISSUE) && !rdone_q && ((credits_q != '0) || r_hs);
  assign rom_req_o  = issue && !beat_err;
  assign rom_addr_o = rom_req_o ? idx[IdxW-1:0] : '0;
  assign push       = dl_vld_q[RomLatency-1];

  always_comb begin
    rstate_d  = rstate_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    rlen_d    = rlen_q;
    rsize_d   = rsize_q;
    rburst_d  = rburst_q;
    rcnt_d    = rcnt_q;
    rdone_d   = rdone_q;
    ar_ready  = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        ar_ready = init_q;
        if (init_q && axi_req_i.ar_valid) begin
          rid_d    = axi_req_i.ar.id;
          raddr_d  = axi_req_i.ar.addr;
          rlen_d   = axi_req_i.ar.len;
          rsize_d  = axi_req_i.ar.size;
          rburst_d = (axi_req_i.ar.burst == 2'b10 && !ar_wrap_ok) ? 2'b01 : axi_req_i.ar.burst;
          rcnt_d   = axi_req_i.ar.len;
          rdone_d  = 1'b0;
          rstate_d = R_ISSUE;
        end
      end
      R_ISSUE: begin
        if (issue) begin
          raddr_d = next_addr;
          rcnt_d  = rcnt_q - 8'd1;
          if (rcnt_q == 8'd0) rdone_d = 1'b1;
        end
        if (r_hs && r_last) rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
    credits_d = credits_q - CrW'(issue) + CrW'(r_hs);
  end

  always_comb begin
    wstate_d = wstate_q;
    wid_d    = wid_q;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        aw_ready = init_q;
        if (init_q && axi_req_i.aw_valid) begin
          wid_d    = axi_req_i.aw.id;
          wstate_d = W_DRAIN;
        end
      end
      W_DRAIN: begin
        w_ready = 1'b1;
        if (axi_req_i.w_valid && axi_req_i.w.last) wstate_d = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (axi_req_i.b_ready) wstate_d = W_IDLE;
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ndmreset) begin
      rstate_q  <= R_IDLE;
      wstate_q  <= W_IDLE;
      init_q    <= 1'b0;
      rid_q     <= '0;
      wid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rcnt_q    <= '0;
      rdone_q   <= 1'b0;
      credits_q <= CrW'(D);
      dl_vld_q  <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      fcnt_q    <= '0;
    end else begin
      rstate_q  <= rstate_d;
      wstate_q  <= wstate_d;
      init_q    <= 1'b1;
      rid_q     <= rid_d;
      wid_q     <= wid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rcnt_q    <= rcnt_d;
      rdone_q   <= rdone_d;
      credits_q <= credits_d;
      dl_vld_q[0] <= issue;
      for (int unsigned i = 1; i < RomLatency; i++) dl_vld_q[i] <= dl_vld_q[i-1];
      if (push) wptr_q <= (wptr_q == PtrW'(D-1)) ? '0 : wptr_q + PtrW'(1);
      if (r_hs) rptr_q <= (rptr_q == PtrW'(D-1)) ? '0 : rptr_q + PtrW'(1);
      fcnt_q <= fcnt_q + CrW'(push) - CrW'(r_hs);
    end
  end

  always_ff @(posedge clk) begin
    dl_err_q[0]  <= beat_err;
    dl_last_q[0] <= (rcnt_q == 8'd0);
    for (int unsigned i = 1; i < RomLatency; i++) begin
      dl_err_q[i]  <= dl_err_q[i-1];
      dl_last_q[i] <= dl_last_q[i-1];
    end
    if (push) begin
      fdata_q[wptr_q] <= dl_err_q[RomLatency-1] ? '0 : rom_rdata_i;
      fresp_q[wptr_q] <= dl_err_q[RomLatency-1] ? 2'b10 : 2'b00;
      flast_q[wptr_q] <= dl_last_q[RomLatency-1];
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.ar_ready = ar_ready;
    axi_resp_o.aw_ready = aw_ready;
    axi_resp_o.w_ready  = w_ready;
    axi_resp_o.b_valid  = b_valid;
    axi_resp_o.b.id     = wid_q;
    axi_resp_o.b.resp   = 2'b10;
    axi_resp_o.b.user   = UserZero;
    axi_resp_o.r_valid  = r_valid;
    axi_resp_o.r.id     = rid_q;
    axi_resp_o.r.data   = fdata_q[rptr_q];
    axi_resp_o.r.resp   = fresp_q[rptr_q];
    axi_resp_o.r.last   = r_last;
    axi_resp_o.r.user   = UserZero;
  end

endmodule

// File: tb/tb_axi_rom_burst.sv
// Directed bench for axi_rom_burst: one instance at RomLatency=1, one at RomLatency=3.

module tb_axi_rom_burst;
  localparam logic [63:0] Base = 64'h1_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              ndmreset;
  ariane_axi::req_t  req1, req3;
  ariane_axi::resp_t rsp1, rsp3;
  logic              rreq1, rreq3;
  logic [9:0]        raddr1, raddr3;
  logic [63:0]       rdata1, rdata3;
  logic [63:0]       p3 [3];

  int nvec = 0;
  int nerr = 0;
  logic [9:0] ei [16];
  bit         ee [16];

  function automatic logic [63:0] romf(input logic [9:0] i);
    logic [31:0] h;
    h = {22'd0, i} * 32'h9E37_79B9;
    return {16'hB007, 6'd0, i, h};
  endfunction

  always_ff @(posedge clk) rdata1 <= romf(raddr1);
  always_ff @(posedge clk) begin
    p3[0] <= romf(raddr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign rdata3 = p3[2];

  axi_rom_burst #(.RomLatency(1)) u_l1 (
    .clk(clk), .ndmreset(ndmreset), .axi_req_i(req1), .axi_resp_o(rsp1),
    .rom_req_o(rreq1), .rom_addr_o(raddr1), .rom_rdata_i(rdata1));

  axi_rom_burst #(.RomLatency(3)) u_l3 (
    .clk(clk), .ndmreset(ndmreset), .axi_req_i(req3), .axi_resp_o(rsp3),
    .rom_req_o(rreq3), .rom_addr_o(raddr3), .rom_rdata_i(rdata3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input int i0, input int i1, input int i2, input int i3,
                      input bit e0, input bit e1, input bit e2, input bit e3);
    for (int i = 0; i < 16; i++) begin ei[i] = '0; ee[i] = 1'b0; end
    ei[0] = 10'(i0); ei[1] = 10'(i1); ei[2] = 10'(i2); ei[3] = 10'(i3);
    ee[0] = e0; ee[1] = e1; ee[2] = e2; ee[3] = e3;
  endtask

  // AR on the latency-1 instance, then cycle-exact checks of ROM strobes and R beats.
  task automatic burst_l1(input string tag, input logic [3:0] id, input logic [63:0] addr,
                          input logic [7:0] len, input logic [1:0] burst);
    int j;
    int r;
    chk({tag, "_arready_pre"}, rsp1.ar_ready, 64'd1);
    req1.ar.id    = id;
    req1.ar.addr  = addr;
    req1.ar.len   = len;
    req1.ar.size  = 3'd3;
    req1.ar.burst = burst;
    req1.ar_valid = 1'b1;
    tick();
    req1.ar_valid = 1'b0;
    for (int k = 1; k <= int'(len) + 3; k++) begin
      j = k - 1;
      r = k - 3;
      if (k == 1) chk({tag, "_arready_low"}, rsp1.ar_ready, 64'd0);
      if (j <= int'(len)) begin
        chk({tag, "_romreq"}, rreq1, {63'd0, !ee[j]});
        chk({tag, "_romaddr"}, raddr1, ee[j] ? 64'd0 : 64'(ei[j]));
      end else begin
        chk({tag, "_romreq_idle"}, rreq1, 64'd0);
      end
      if (r >= 0 && r <= int'(len)) begin
        chk({tag, "_rvalid"}, rsp1.r_valid, 64'd1);
        chk({tag, "_rdata"}, rsp1.r.data, ee[r] ? 64'd0 : romf(ei[r]));
        chk({tag, "_rresp"}, rsp1.r.resp, ee[r] ? 64'd2 : 64'd0);
        chk({tag, "_rlast"}, rsp1.r.last, (r == int'(len)) ? 64'd1 : 64'd0);
        chk({tag, "_rid"}, rsp1.r.id, 64'(id));
      end else begin
        chk({tag, "_rvalid_low"}, rsp1.r_valid, 64'd0);
      end
      tick();
    end
    chk({tag, "_arready_post"}, rsp1.ar_ready, 64'd1);
    chk({tag, "_rvalid_post"}, rsp1.r_valid, 64'd0);
  endtask

  initial begin
    int issued, hs, maxinf, stray;
    bit stalled, ok;
    logic [63:0] pdata;
    logic plast;

    req1 = '0;
    req3 = '0;
    req1.r_ready = 1'b1;
    req1.b_ready = 1'b1;
    ndmreset = 1'b1;
    repeat (3) tick();
    chk("rst_arready", rsp1.ar_ready, 64'd0);
    chk("rst_awready", rsp1.aw_ready, 64'd0);
    chk("rst_wready",  rsp1.w_ready,  64'd0);
    chk("rst_rvalid",  rsp1.r_valid,  64'd0);
    chk("rst_bvalid",  rsp1.b_valid,  64'd0);
    chk("rst_romreq",  rreq1,         64'd0);
    chk("rst_romaddr", raddr1,        64'd0);
    ndmreset = 1'b0;
    tick();
    chk("init_arready",    rsp1.ar_ready, 64'd1);
    chk("init_awready",    rsp1.aw_ready, 64'd1);
    chk("init_l3_arready", rsp3.ar_ready, 64'd1);

    set4(1, 2, 3, 4, 0, 0, 0, 0);
    burst_l1("incr", 4'd3, Base + 64'h8, 8'd3, 2'b01);
    set4(3, 0, 1, 2, 0, 0, 0, 0);
    burst_l1("wrap", 4'd4, Base + 64'h18, 8'd3, 2'b10);
    set4(5, 5, 5, 0, 0, 0, 0, 0);
    burst_l1("fixed", 4'd6, Base + 64'h28, 8'd2, 2'b00);
    set4(3, 4, 5, 0, 0, 0, 0, 0);
    burst_l1("wrap_len2", 4'd8, Base + 64'h18, 8'd2, 2'b10);
    set4(1022, 1023, 0, 0, 0, 0, 1, 1);
    burst_l1("cross_end", 4'd10, Base + 64'h1FF0, 8'd3, 2'b01);
    set4(0, 0, 0, 0, 1, 0, 0, 0);
    burst_l1("below_base", 4'd11, 64'h8, 8'd0, 2'b01);

    // Write burst (3 beats) alongside a 2-beat read
    req1.aw.id    = 4'd5;
    req1.aw_valid = 1'b1;
    req1.ar.id    = 4'd2;
    req1.ar.addr  = Base + 64'h10;
    req1.ar.len   = 8'd1;
    req1.ar.size  = 3'd3;
    req1.ar.burst = 2'b01;
    req1.ar_valid = 1'b1;
    tick();
    req1.aw_valid = 1'b0;
    req1.ar_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      req1.w_valid = (k <= 3);
      req1.w.last  = (k == 3);
      chk("wr_wready", rsp1.w_ready, (k <= 3) ? 64'd1 : 64'd0);
      chk("wr_bvalid", rsp1.b_valid, (k == 4) ? 64'd1 : 64'd0);
      if (k == 1) chk("wr_awready_low", rsp1.aw_ready, 64'd0);
      if (k == 4) begin
        chk("wr_bresp", rsp1.b.resp, 64'd2);
        chk("wr_bid",   rsp1.b.id,   64'd5);
      end
      if (k == 5) begin
        chk("wr_awready_back", rsp1.aw_ready, 64'd1);
        chk("wr_rd_arready",   rsp1.ar_ready, 64'd1);
      end
      chk("wr_rd_rvalid", rsp1.r_valid, (k == 3 || k == 4) ? 64'd1 : 64'd0);
      if (k == 3 || k == 4) begin
        chk("wr_rd_rdata", rsp1.r.data, romf(10'(k - 1)));
        chk("wr_rd_rlast", rsp1.r.last, (k == 4) ? 64'd1 : 64'd0);
        chk("wr_rd_rid",   rsp1.r.id,   64'd2);
      end
      tick();
    end
    req1.w_valid = 1'b0;
    req1.w.last  = 1'b0;

    // Latency-3 instance, 8 beats with rready cycling 1-0-0-1
    req3.ar.id    = 4'd7;
    req3.ar.addr  = Base;
    req3.ar.len   = 8'd7;
    req3.ar.size  = 3'd3;
    req3.ar.burst = 2'b01;
    req3.ar_valid = 1'b1;
    tick();
    req3.ar_valid = 1'b0;
    issued = 0; hs = 0; maxinf = 0; stalled = 1'b0; pdata = '0; plast = 1'b0;
    for (int c = 0; c < 200 && hs < 8; c++) begin
      req3.r_ready = (c % 4 == 0) || (c % 4 == 3);
      #1;
      if (rreq3) begin
        chk("l3_romaddr", raddr3, 64'(issued));
        issued++;
      end
      if (stalled) begin
        chk("l3_hold_valid", rsp3.r_valid, 64'd1);
        chk("l3_hold_data",  rsp3.r.data,  pdata);
        chk("l3_hold_last",  rsp3.r.last,  {63'd0, plast});
      end
      if (rsp3.r_valid && req3.r_ready) begin
        chk("l3_rdata", rsp3.r.data, romf(10'(hs)));
        chk("l3_rlast", rsp3.r.last, (hs == 7) ? 64'd1 : 64'd0);
        chk("l3_rresp", rsp3.r.resp, 64'd0);
        hs++;
        stalled = 1'b0;
      end else if (rsp3.r_valid) begin
        stalled = 1'b1;
        pdata   = rsp3.r.data;
        plast   = rsp3.r.last;
      end else begin
        stalled = 1'b0;
      end
      if (issued - hs > maxinf) maxinf = issued - hs;
      @(posedge clk);
      #1;
    end
    chk("l3_beats",        64'(hs),     64'd8);
    chk("l3_issued",       64'(issued), 64'd8);
    chk("l3_inflight_le4", {63'd0, maxinf <= 4}, 64'd1);
    chk("l3_arready_post", rsp3.ar_ready, 64'd1);
    req3.r_ready = 1'b0;

    // Reset in the middle of a 16-beat burst
    req1.ar.id    = 4'd9;
    req1.ar.addr  = Base;
    req1.ar.len   = 8'd15;
    req1.ar.size  = 3'd3;
    req1.ar.burst = 2'b01;
    req1.ar_valid = 1'b1;
    tick();
    req1.ar_valid = 1'b0;
    tick();
    tick();
    chk("mid_beat1", rsp1.r.data, romf(10'd0));
    tick();
    chk("mid_beat2_valid", rsp1.r_valid, 64'd1);
    chk("mid_beat2_data",  rsp1.r.data,  romf(10'd1));
    ndmreset = 1'b1;
    tick();
    chk("mid_rst_rvalid",  rsp1.r_valid,  64'd0);
    chk("mid_rst_arready", rsp1.ar_ready, 64'd0);
    chk("mid_rst_romreq",  rreq1,         64'd0);
    ndmreset = 1'b0;
    ok = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rsp1.r_valid) stray++;
      if (rsp1.ar_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_arready_back", {63'd0, ok}, 64'd1);
    chk("mid_no_stray_r",   64'(stray),  64'd0);
    set4(0, 1, 2, 3, 0, 0, 0, 0);
    burst_l1("post_rst", 4'd1, Base, 8'd3, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
